// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes,
// state encoding and datapath mux select encodings.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    EXEC_U   = 4'd5,
    ALU_WB   = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JALR     = 4'd13,
    TRAP     = 4'd14,
    FAULT    = 4'd15
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_RFUNC = 2'b10;
  localparam logic [1:0] ALUOP_IFUNC = 2'b11;

  // States in which the FSM waits on the memory handshake.
  function automatic logic is_mem_wait(state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Saturating memory-wait counter. limit_reached flags the wait cycle on
// which the count arrives at LIMIT.
module ctrl_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Count wait cycles; clear has priority; hold at LIMIT instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && (cnt != CW'(LIMIT)))
      cnt <= cnt + 1'b1;
  end

  assign limit_reached = enable && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with memory req/ready handshake, bus
// timeout and illegal-opcode trap.
// Optional: define CTRL_UPPER_IMM_EN to execute LUI/AUIPC via EXEC_U.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned IMM_SRC_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic [1:0]           result_src,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [3:0]           state
);

  state_t state_q, state_d;
  logic   tmo_hit;

  ctrl_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (state_d != state_q),
    .enable        (is_mem_wait(state_q) && !mem_ready),
    .limit_reached (tmo_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and output decode; mem_ready is checked before the timeout
  // so a completion on the limit cycle wins.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PCSRC_ALU;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    imm_src       = '0;
    result_src    = RES_ALUOUT;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          state_d = FAULT;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_SRC_W'(IMM_B);
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          OP_JALR:            state_d = JALR;
`ifdef CTRL_UPPER_IMM_EN
          OP_LUI, OP_AUIPC:   state_d = EXEC_U;
`endif
          default:            state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_RFUNC;
        state_d   = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_SRC_W'(IMM_I);
        alu_op    = ALUOP_IFUNC;
        state_d   = ALU_WB;
      end
`ifdef CTRL_UPPER_IMM_EN
      EXEC_U: begin
        alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_SRC_W'(IMM_U);
        state_d   = ALU_WB;
      end
`endif
      ALU_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_STORE) begin
          imm_src = IMM_SRC_W'(IMM_S);
          state_d = MEM_WR;
        end else begin
          imm_src = IMM_SRC_W'(IMM_I);
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_d = MEM_WB;
        else if (tmo_hit) state_d = FAULT;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_d = FETCH;
        else if (tmo_hit) state_d = FAULT;
      end
      BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_CMP;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = branch_taken;
        state_d   = FETCH;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        state_d    = FETCH;
      end
      JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_SRC_W'(IMM_I);
        pc_write   = 1'b1;
        pc_src     = PCSRC_JALR;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        state_d    = FETCH;
      end
      TRAP: begin
        illegal_instr = 1'b1;
        state_d       = FETCH;
      end
      FAULT: begin
        bus_error = 1'b1;
        state_d   = FAULT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm with an expected-output
// scoreboard; state numbers and mux encodings are restated locally.
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_EXR  = 4'd3,  S_EXI   = 4'd4,  S_EXU    = 4'd5,
                         S_AWB  = 4'd6,  S_MADR  = 4'd7,  S_MRD    = 4'd8,
                         S_MWB  = 4'd9,  S_MWR   = 4'd10, S_BR     = 4'd11,
                         S_JAL  = 4'd12, S_JALR  = 4'd13, S_TRAP   = 4'd14,
                         S_FAULT = 4'd15;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_LUI = 7'b0110111,
                         O_AUIPC = 7'b0010111, O_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] a, b, op;
    logic [2:0] imm;
    logic [1:0] res;
    logic       illegal, bus_error;
  } outs_t;

  typedef struct {
    logic [6:0] opc;
    logic       bt;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic       illegal_instr, bus_error;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [3:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  vec_t        vecs[$];
  sb_t         sbq[$];

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .IMM_SRC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .result_src(result_src), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .state(state)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given state and inputs.
  function automatic outs_t model(logic [3:0] st, logic [6:0] opc, logic bt, logic mr);
    outs_t o = '0;
    o.st = st;
    case (st)
      S_FETCH:  begin o.mem_req = 1; o.b = 2'b10; o.ir_write = mr; o.pc_write = mr; end
      S_DECODE: begin o.a = 2'b01; o.b = 2'b01; o.imm = 3'b010; end
      S_EXR:    begin o.a = 2'b10; o.op = 2'b10; end
      S_EXI:    begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b11; end
      S_EXU:    begin o.a = (opc == O_LUI) ? 2'b11 : 2'b01; o.b = 2'b01; o.imm = 3'b100; end
      S_AWB:    o.reg_write = 1;
      S_MADR:   begin o.a = 2'b10; o.b = 2'b01; o.imm = (opc == O_ST) ? 3'b001 : 3'b000; end
      S_MRD:    begin o.mem_req = 1; o.adr_src = 1; end
      S_MWB:    begin o.reg_write = 1; o.res = 2'b01; end
      S_MWR:    begin o.mem_req = 1; o.mem_we = 1; o.adr_src = 1; end
      S_BR:     begin o.a = 2'b10; o.op = 2'b01; o.pc_src = 2'b01; o.pc_write = bt; end
      S_JAL:    begin o.pc_write = 1; o.pc_src = 2'b01; o.reg_write = 1; o.res = 2'b10; end
      S_JALR:   begin o.a = 2'b10; o.b = 2'b01; o.pc_write = 1; o.pc_src = 2'b10;
                      o.reg_write = 1; o.res = 2'b10; end
      S_TRAP:   o.illegal = 1;
      S_FAULT:  o.bus_error = 1;
      default:  ;
    endcase
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.adr_src = adr_src;
    o.ir_write = ir_write; o.pc_write = pc_write; o.pc_src = pc_src;
    o.reg_write = reg_write; o.a = alu_src_a; o.b = alu_src_b; o.op = alu_op;
    o.imm = imm_src; o.res = result_src; o.illegal = illegal_instr; o.bus_error = bus_error;
    return o;
  endfunction

  task automatic push(input string name, input outs_t e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic check_front();
    sb_t   s;
    outs_t got;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: empty at sample time");
      return;
    end
    s   = sbq.pop_front();
    got = observed();
    n_cmp++;
    if (got !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)",
               s.name, got, s.exp, got.st, s.exp.st);
    end
  endtask

  task automatic add(input logic [6:0] opc, input logic bt, input logic mr, input logic [3:0] st);
    vec_t v;
    v.opc = opc; v.bt = bt; v.mr = mr; v.st = st;
    vecs.push_back(v);
  endtask

  // One clock: drive at negedge, record expectation, sample 2 ns later.
  task automatic step(input string name, input logic [6:0] opc, input logic bt,
                      input logic mr, input logic [3:0] st);
    @(negedge clk);
    opcode = opc; branch_taken = bt; mem_ready = mr;
    push(name, model(st, opc, bt, mr));
    #2;
    check_front();
  endtask

  initial begin
    // ADDI, ready on first fetch cycle
    add(0, 0, 1, S_FETCH); add(O_I, 0, 0, S_DECODE); add(O_I, 0, 0, S_EXI); add(O_I, 0, 0, S_AWB);
    // LW: two fetch waits, three MEM_RD waits (counter must clear between)
    add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH); add(0, 0, 1, S_FETCH);
    add(O_LD, 0, 0, S_DECODE); add(O_LD, 0, 0, S_MADR);
    add(O_LD, 0, 0, S_MRD); add(O_LD, 0, 0, S_MRD); add(O_LD, 0, 0, S_MRD);
    add(O_LD, 0, 1, S_MRD); add(O_LD, 0, 0, S_MWB);
    // SW with one wait
    add(0, 0, 1, S_FETCH); add(O_ST, 0, 0, S_DECODE); add(O_ST, 0, 0, S_MADR);
    add(O_ST, 0, 0, S_MWR); add(O_ST, 0, 1, S_MWR);
    // R-type
    add(0, 1, 1, S_FETCH); add(O_R, 1, 0, S_DECODE); add(O_R, 1, 0, S_EXR); add(O_R, 1, 0, S_AWB);
    // BEQ not taken, then taken
    add(0, 0, 1, S_FETCH); add(O_BR, 0, 0, S_DECODE); add(O_BR, 0, 0, S_BR);
    add(0, 1, 1, S_FETCH); add(O_BR, 1, 0, S_DECODE); add(O_BR, 1, 0, S_BR);
    // JAL, JALR
    add(0, 0, 1, S_FETCH); add(O_JAL, 0, 0, S_DECODE); add(O_JAL, 0, 0, S_JAL);
    add(0, 0, 1, S_FETCH); add(O_JALR, 0, 0, S_DECODE); add(O_JALR, 0, 0, S_JALR);
    // Illegal opcode
    add(0, 0, 1, S_FETCH); add(O_BAD, 0, 0, S_DECODE); add(O_BAD, 0, 0, S_TRAP);
    // LUI / AUIPC
    add(0, 0, 1, S_FETCH); add(O_LUI, 0, 0, S_DECODE);
`ifdef CTRL_UPPER_IMM_EN
    add(O_LUI, 0, 0, S_EXU); add(O_LUI, 0, 0, S_AWB);
`else
    add(O_LUI, 0, 0, S_TRAP);
`endif
    add(0, 0, 1, S_FETCH); add(O_AUIPC, 0, 0, S_DECODE);
`ifdef CTRL_UPPER_IMM_EN
    add(O_AUIPC, 0, 0, S_EXU); add(O_AUIPC, 0, 0, S_AWB);
`else
    add(O_AUIPC, 0, 0, S_TRAP);
`endif
    // mem_ready on the limit cycle: no fault
    add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH); add(0, 0, 1, S_FETCH);
    add(O_I, 0, 0, S_DECODE); add(O_I, 0, 0, S_EXI); add(O_I, 0, 0, S_AWB);
    // four fetch waits -> FAULT, sticky even with ready
    add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH); add(0, 0, 0, S_FETCH);
    add(0, 0, 1, S_FAULT); add(0, 0, 1, S_FAULT); add(O_I, 1, 1, S_FAULT);

    // Reset state
    @(negedge clk);
    push("reset_low", '0);
    #2 check_front();
    @(negedge clk);
    rst_n = 1'b1;
    push("reset_release_idle", '0);
    #2 check_front();

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].opc, vecs[i].bt, vecs[i].mr, vecs[i].st);

    // Reset out of FAULT is asynchronous
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    push("fault_async_reset", '0);
    #2 check_front();
    @(negedge clk);
    rst_n = 1'b1;
    push("post_fault_idle", '0);
    #2 check_front();

    // Reset mid-wait must clear the counter: 2 waits, reset, then 3 waits + ready
    step("mid_wait_f0", 0, 0, 0, S_FETCH);
    step("mid_wait_f1", 0, 0, 0, S_FETCH);
    @(negedge clk);
    rst_n = 1'b0;
    push("mid_wait_reset", '0);
    #2 check_front();
    @(negedge clk);
    rst_n = 1'b1;
    push("mid_wait_release", '0);
    #2 check_front();
    step("cnt_clr_f0", 0, 0, 0, S_FETCH);
    step("cnt_clr_f1", 0, 0, 0, S_FETCH);
    step("cnt_clr_f2", 0, 0, 0, S_FETCH);
    step("cnt_clr_f3", 0, 0, 1, S_FETCH);
    step("cnt_clr_dec", O_R, 0, 0, S_DECODE);

    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
